// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
//
// Shared definitions for the data-memory responder and its backing array:
//   - WORD_W          : data/address word width in bits
//   - BYTES_PER_WORD  : byte lanes per word (width of the byte-enable vector)
//   - CNT_W           : width of the access-latency down-counter
//   - state_t         : responder control states (IDLE, BUSY, RESP)
//
// Optional feature macro used by the importing files: DMEM_BYTE_EN.
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
//
// Word-addressed backing store for the data-memory responder.
// Synchronous write with per-byte enables, combinational read.
// Contents are not reset.
//
// Ports:
//   clk    in   write clock (rising edge)
//   we     in   write strobe for the addressed word
//   be     in   byte-lane enables, bit i = byte i (all ones for full-word)
//   index  in   word index, DMEM_POWER bits
//   wdata  in   write data
//   rdata  out  read data for the word at index (combinational)
//
// Parameters:
//   DMEM_POWER  log2 of the number of words
// ---------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DMEM_POWER = 18
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [BYTES_PER_WORD-1:0] be,
    input  logic [DMEM_POWER-1:0]     index,
    input  logic [WORD_W-1:0]         wdata,
    output logic [WORD_W-1:0]         rdata
);

    localparam int unsigned DEPTH = 2 ** DMEM_POWER;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
                if (be[i]) begin
                    mem[index][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Target side of the pipeline memory-stage data access. Accepts one
// word-granular read or write at a time over a valid/ready request channel,
// performs it on the backing array LATENCY cycles after acceptance, and
// returns a response (read data + error flag) over a valid/ready response
// channel. Only one request is outstanding; requests presented while busy or
// while a response is pending are ignored.
//
// Ports:
//   clk         in   clock, all state on rising edge
//   reset       in   asynchronous active-low reset of all control state
//   req_valid   in   request present
//   req_ready   out  responder idle and able to accept a request
//   req_we      in   1 = write, 0 = read
//   req_addr    in   byte address
//   req_wdata   in   write data
//   req_be      in   byte enables (only when DMEM_BYTE_EN is defined)
//   resp_valid  out  response present
//   resp_ready  in   initiator accepts the response
//   resp_rdata  out  read data; zero for writes and errored requests
//   resp_err    out  request was misaligned or out of range
//
// Parameters:
//   DMEM_POWER  log2 of array depth in words
//   LATENCY     cycles from acceptance to response valid, 1..15
//
// Configuration macro:
//   DMEM_BYTE_EN  adds req_be; writes update only enabled byte lanes.
//                 Without it every write updates the whole word.
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DMEM_POWER = 18,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [WORD_W-1:0]         req_addr,
    input  logic [WORD_W-1:0]         req_wdata,
`ifdef DMEM_BYTE_EN
    input  logic [BYTES_PER_WORD-1:0] req_be,
`endif
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [WORD_W-1:0]         resp_rdata,
    output logic                      resp_err
);

    // Counter starts at LATENCY-1 so the access lands on the LATENCY-th edge
    // after acceptance.
    localparam logic [CNT_W-1:0] COUNT_LOAD = CNT_W'(LATENCY - 1);

    state_t                    state;
    logic [CNT_W-1:0]          count;

    logic                      r_we;
    logic [WORD_W-1:0]         r_addr;
    logic [WORD_W-1:0]         r_wdata;
    logic [BYTES_PER_WORD-1:0] r_be;

    logic [DMEM_POWER-1:0]     index;
    logic                      addr_err;
    logic                      access_now;
    logic                      array_we;
    logic [WORD_W-1:0]         array_rdata;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    // Decode of the captured request address.
    assign index    = r_addr[DMEM_POWER+1:2];
    assign addr_err = (r_addr[1:0] != 2'b00) ||
                      ((r_addr >> (DMEM_POWER + 2)) != '0);

    assign access_now = (state == BUSY) && (count == '0);
    // Errored writes must never reach the array, otherwise an out-of-range
    // address would alias onto the truncated index.
    assign array_we   = access_now && r_we && !addr_err;

    // Control and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        count   <= COUNT_LOAD;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (count == '0) begin
                        resp_err   <= addr_err;
                        resp_rdata <= (addr_err || r_we) ? '0 : array_rdata;
                        state      <= RESP;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_BYTE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_be <= '0;
        end else if (state == IDLE && req_valid) begin
            r_be <= req_be;
        end
    end
`else
    assign r_be = '1;
`endif

    dmem_array #(
        .DMEM_POWER (DMEM_POWER)
    ) u_array (
        .clk   (clk),
        .we    (array_we),
        .be    (r_be),
        .index (index),
        .wdata (r_wdata),
        .rdata (array_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Self-checking bench for dmem_responder. A transaction-level reference
// model (accept time + LATENCY, associative-array memory with per-byte
// known masks) predicts req_ready/resp_valid/resp_rdata/resp_err; a compare
// process checks them every falling edge. Directed transactions also check
// hand-computed literal results. Honours DMEM_BYTE_EN.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int unsigned DMEM_POWER = 18;
    localparam int unsigned LATENCY    = 2;
`ifdef DMEM_BYTE_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int tests  = 0;
    int errors = 0;

    dmem_responder #(
        .DMEM_POWER (DMEM_POWER),
        .LATENCY    (LATENCY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
`ifdef DMEM_BYTE_EN
        .req_be     (req_be),
`endif
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Check helpers
    // ------------------------------------------------------------------
    task automatic check_val(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        tests++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: one outstanding transaction, response due exactly
    // LATENCY edges after acceptance, held until the response handshake.
    // ------------------------------------------------------------------
    logic [31:0] mdata  [int unsigned];
    logic [3:0]  mknown [int unsigned];

    int unsigned edge_n = 0;
    int unsigned m_due  = 0;
    bit          m_busy = 1'b0;
    bit          m_resp = 1'b0;
    logic        m_we   = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_be   = '0;
    logic [31:0] m_rdata = '0;
    logic [3:0]  m_mask = 4'hF;
    logic        m_err  = 1'b0;

    task automatic model_access();
        logic [63:0] lim;
        int unsigned w;
        logic [31:0] v;
        logic [3:0]  k;
        lim = 64'd1 << (DMEM_POWER + 2);
        w   = m_addr >> 2;
        m_err   = (m_addr % 4 != 0) || ({32'd0, m_addr} >= lim);
        m_rdata = '0;
        m_mask  = 4'hF;
        if (!m_err) begin
            if (m_we) begin
                v = mdata.exists(w) ? mdata[w] : 32'd0;
                k = mknown.exists(w) ? mknown[w] : 4'h0;
                for (int b = 0; b < 4; b++) begin
                    if (m_be[b]) begin
                        v[8*b +: 8] = m_wdata[8*b +: 8];
                        k[b] = 1'b1;
                    end
                end
                mdata[w]  = v;
                mknown[w] = k;
            end else begin
                m_rdata = mdata.exists(w) ? mdata[w] : 32'd0;
                m_mask  = mknown.exists(w) ? mknown[w] : 4'h0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_busy  = 1'b0;
            m_resp  = 1'b0;
            m_rdata = '0;
            m_err   = 1'b0;
            m_mask  = 4'hF;
        end else begin
            edge_n++;
            if (m_resp) begin
                if (resp_ready) begin
                    m_resp  = 1'b0;
                    m_rdata = '0;
                    m_err   = 1'b0;
                    m_mask  = 4'hF;
                end
            end else if (m_busy) begin
                if (edge_n == m_due) begin
                    model_access();
                    m_busy = 1'b0;
                    m_resp = 1'b1;
                end
            end else if (req_valid) begin
                m_we    = req_we;
                m_addr  = req_addr;
                m_wdata = req_wdata;
                m_be    = BYTE_EN ? req_be : 4'hF;
                m_busy  = 1'b1;
                m_due   = edge_n + LATENCY;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        logic [31:0] bm;
        @(negedge clk);
        for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{m_mask[b]}};
        check_bit("cyc_req_ready", req_ready, !(m_busy || m_resp));
        check_bit("cyc_resp_valid", resp_valid, m_resp);
        check_bit("cyc_resp_err", resp_err, m_err);
        check_val("cyc_resp_rdata", resp_rdata & bm, m_rdata & bm);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive_garbage();
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom_range(0, 15));
    endtask

    task automatic transact(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input int hold, output logic [31:0] rd,
                            output logic err, output int lat);
        int n;
        n   = 0;
        rd  = '1;
        err = 1'bx;
        lat = -1;
        while (!req_ready && n < 32) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            bound_fail("req_ready_wait");
            return;
        end
        resp_ready = (hold == 0);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_be     = be;
        @(posedge clk); #1;
        lat = 0;
        while (!resp_valid && lat < 64) begin
            drive_garbage();
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid) begin
            bound_fail("resp_valid_wait");
            req_valid  = 1'b0;
            resp_ready = 1'b1;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            drive_garbage();
            @(posedge clk); #1;
        end
        rd  = resp_rdata;
        err = resp_err;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic [31:0] addr;
        int          r;

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_be     = 4'hF;
        resp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_bit("reset_req_ready", req_ready, 1'b1);
        check_bit("reset_resp_valid", resp_valid, 1'b0);
        check_val("reset_resp_rdata", resp_rdata, 32'h0);
        check_bit("reset_resp_err", resp_err, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Write then read back 0x10.
        transact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, err, lat);
        check_val("wr10_rdata", rd, 32'h0);
        check_bit("wr10_err", err, 1'b0);
        check_val("wr10_latency", 32'(lat), 32'(LATENCY));
        transact(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, err, lat);
        check_val("rd10_rdata", rd, 32'hDEADBEEF);
        check_bit("rd10_err", err, 1'b0);
        check_val("rd10_latency", 32'(lat), 32'(LATENCY));

        // Misaligned access.
        transact(1'b0, 32'h13, 32'h0, 4'hF, 0, rd, err, lat);
        check_val("rd13_rdata", rd, 32'h0);
        check_bit("rd13_err", err, 1'b1);
        transact(1'b1, 32'h13, 32'h77777777, 4'hF, 0, rd, err, lat);
        check_bit("wr13_err", err, 1'b1);
        transact(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, err, lat);
        check_val("rd10_after_wr13", rd, 32'hDEADBEEF);

        // Out of range: no aliasing onto index 0.
        transact(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, rd, err, lat);
        check_bit("wr0_err", err, 1'b0);
        transact(1'b1, 32'h0010_0000, 32'h0BADBAD0, 4'hF, 0, rd, err, lat);
        check_bit("wr_oor_err", err, 1'b1);
        transact(1'b0, 32'h0010_0000, 32'h0, 4'hF, 0, rd, err, lat);
        check_bit("rd_oor_err", err, 1'b1);
        check_val("rd_oor_rdata", rd, 32'h0);
        transact(1'b0, 32'h0, 32'h0, 4'hF, 0, rd, err, lat);
        check_val("rd0_no_alias", rd, 32'hCAFEF00D);

        // Response held with resp_ready low for 5 cycles.
        transact(1'b0, 32'h10, 32'h0, 4'hF, 5, rd, err, lat);
        check_val("hold_rdata", rd, 32'hDEADBEEF);
        check_bit("hold_err", err, 1'b0);

        // Reset during BUSY of a write discards it.
        transact(1'b1, 32'h20, 32'h12345678, 4'hF, 0, rd, err, lat);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h55;
        req_be    = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_bit("rst_busy_req_ready", req_ready, 1'b0);
        #1 reset = 1'b0;
        #1 reset = 1'b1;
        check_bit("rst_after_req_ready", req_ready, 1'b1);
        check_bit("rst_after_resp_valid", resp_valid, 1'b0);
        @(posedge clk); #1;
        transact(1'b0, 32'h20, 32'h0, 4'hF, 0, rd, err, lat);
        check_val("rd20_after_rst", rd, 32'h12345678);

`ifdef DMEM_BYTE_EN
        transact(1'b1, 32'h40, 32'h11223344, 4'hF, 0, rd, err, lat);
        transact(1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, 0, rd, err, lat);
        transact(1'b0, 32'h40, 32'h0, 4'hF, 0, rd, err, lat);
        check_val("be_merge", rd, 32'h11BB33DD);
        transact(1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, 0, rd, err, lat);
        check_bit("be_zero_err", err, 1'b0);
        transact(1'b0, 32'h40, 32'h0, 4'hF, 0, rd, err, lat);
        check_val("be_zero_noop", rd, 32'h11BB33DD);
`endif

        // Randomised traffic; the per-cycle compare does the checking.
        for (int t = 0; t < 80; t++) begin
            r = int'($urandom_range(0, 99));
            addr = 32'h100 + 32'($urandom_range(0, 7)) * 4;
            if (r < 10) addr = addr + 32'($urandom_range(1, 3));
            else if (r < 15) addr = ($urandom | 32'h0010_0000) & 32'hFFFF_FFFC;
            transact(1'($urandom_range(0, 1)), addr, $urandom,
                     4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                     rd, err, lat);
            check_val("rand_latency", 32'(lat), 32'(LATENCY));
        end

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
